morph_filter: RTL and testbench

MORPH_FILTER -- requirements
Module: morph_filter

---
 rtl/morph_pkg.sv | 17 +
 rtl/morph_line_buf.sv | 41 ++++
 rtl/morph_filter.sv | 171 +++++++++++++++++
 tb/tb_morph_filter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// morph_pkg -- shared definitions for the binary morphology filter.
//   MODE_DILATE / MODE_ERODE : encodings of the mode input
//   state_t                  : frame-synchronisation FSM states
//   SET_CNT_W                : width of the per-frame set-pixel count
package morph_pkg;

    localparam logic MODE_DILATE = 1'b0;
    localparam logic MODE_ERODE  = 1'b1;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    localparam int SET_CNT_W = 20;

endpackage

// File: rtl/morph_line_buf.sv
// morph_line_buf -- KSIZE-1 cascaded single-bit line delays.
//   clk   : clock
//   rst   : synchronous active-high reset, clears all storage
//   shift : advance the delay lines by one pixel
//   din   : pixel entering the first line
//   taps  : taps[i] is the pixel i+1 lines above din (same column)
// Each line is LEN bits long and advances only while shift is high, so a
// line of exactly LEN processed pixels maps one column onto the same column.
module morph_line_buf #(
    parameter int KSIZE = 3,
    parameter int LEN   = 641
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             din,
    output logic [KSIZE-2:0] taps
);

    logic [LEN-1:0] line_q [KSIZE-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KSIZE-1; i++) begin
                line_q[i] <= '0;
            end
        end else if (shift) begin
            line_q[0] <= {line_q[0][LEN-2:0], din};
            for (int i = 1; i < KSIZE-1; i++) begin
                line_q[i] <= {line_q[i][LEN-2:0], line_q[i-1][LEN-1]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < KSIZE-1; i++) begin
            taps[i] = line_q[i][LEN-1];
        end
    end

endmodule

// File: rtl/morph_filter.sv
// morph_filter -- streaming KSIZE x KSIZE binary dilate/erode on a raster.
//   clk, rst  : clock, synchronous active-high reset
//   hcount    : raster column of bin_in
//   vcount    : raster line of bin_in
//   mode      : 0 = dilate, 1 = erode (latched at start of frame)
//   bin_in    : binary input pixel
//   bin_out   : filtered pixel centred at (hcount-R, vcount-R), one cycle later
//   color_out : all ones when bin_out is 1, else zero
//   valid_out : bin_out/color_out carry a real output pixel
//   set_count : number of 1 outputs in the previous frame
// Build option: define MORPH_SET_COUNT_EN to include the set_count counter;
// otherwise set_count is tied to zero.
module morph_filter
    import morph_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int KSIZE    = 3,
    parameter int COLOR_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          hcount,
    input  logic [10:0]          vcount,
    input  logic                 mode,
    input  logic                 bin_in,
    output logic                 bin_out,
    output logic [COLOR_W-1:0]   color_out,
    output logic                 valid_out,
    output logic [SET_CNT_W-1:0] set_count
);

    localparam int R = KSIZE / 2;

    generate
        if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
            $error("morph_filter: KSIZE must be 3 or 5");
        end
    endgenerate

    state_t state_q, state_d;
    logic   run;
    logic   mode_q;
    int     hc, vc;
    logic   sof, proc, pix;
    logic   vld_p0, res_p0;
    logic   vld_p1, bin_p1;
    logic   or_acc, and_acc;

    logic [KSIZE-1:0] col_p0;
    logic [KSIZE-2:0] taps_p0;
    logic [KSIZE-2:0] hsr_p0 [KSIZE];
    logic [KSIZE-1:0] win_p0 [KSIZE];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_SOF;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof) state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run = (state_q == RUN);
    end

    morph_line_buf #(
        .KSIZE (KSIZE),
        .LEN   (H_ACTIVE + R)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .shift (proc),
        .din   (pix),
        .taps  (taps_p0)
    );

    // ---- stage p0: window assembly and kernel evaluation ----
    always_comb begin
        int r, c;
        hc      = int'(hcount);
        vc      = int'(vcount);
        sof     = (hcount == 11'd0) && (vcount == 11'd0);
        pix     = bin_in && (hc < H_ACTIVE) && (vc < V_ACTIVE);
        proc    = (hc < H_ACTIVE + R) && (vc < V_ACTIVE + R);
        vld_p0  = run && (hc >= R) && (hc < H_ACTIVE + R) &&
                  (vc >= R) && (vc < V_ACTIVE + R);
        col_p0  = {taps_p0, pix};
        or_acc  = 1'b0;
        and_acc = 1'b1;
        for (int k = 0; k < KSIZE; k++) begin
            win_p0[k] = {hsr_p0[k], col_p0[k]};
        end
        // Positions outside the image are skipped, which is the same as
        // substituting the neutral value for the current operation.
        for (int k = 0; k < KSIZE; k++) begin
            for (int j = 0; j < KSIZE; j++) begin
                r = vc - k;
                c = hc - j;
                if (r >= 0 && r < V_ACTIVE && c >= 0 && c < H_ACTIVE) begin
                    or_acc  = or_acc  | win_p0[k][j];
                    and_acc = and_acc & win_p0[k][j];
                end
            end
        end
        res_p0 = (mode_q == MODE_ERODE) ? and_acc : or_acc;
    end

    // Horizontal history of each window row; stale contents at line start
    // are excluded by the coordinate mask above.
    always_ff @(posedge clk) begin
        if (proc) begin
            for (int k = 0; k < KSIZE; k++) begin
                hsr_p0[k] <= {hsr_p0[k][KSIZE-3:0], col_p0[k]};
            end
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            bin_p1 <= 1'b0;
            mode_q <= MODE_DILATE;
        end else begin
            vld_p1 <= vld_p0;
            bin_p1 <= vld_p0 && res_p0;
            if (sof) mode_q <= mode;
        end
    end

    assign valid_out = vld_p1;
    assign bin_out   = bin_p1;
    assign color_out = {COLOR_W{bin_p1}};

`ifdef MORPH_SET_COUNT_EN
    logic [SET_CNT_W-1:0] cnt_q, set_q;

    function automatic logic [SET_CNT_W-1:0] sat_inc(input logic [SET_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The frame just ended is published only if it was fully processed
    // (FSM already in RUN); after a reset the partial frame is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            set_q <= '0;
        end else if (sof) begin
            if (run) set_q <= cnt_q;
            cnt_q <= '0;
        end else if (vld_p0 && res_p0) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign set_count = set_q;
`else
    assign set_count = '0;
`endif

endmodule

// File: tb/tb_morph_filter.sv
module tb_morph_filter;
    localparam int H = 16;
    localparam int V = 8;
    localparam int HT = 20;
    localparam int VT = 11;

    // pattern ids for expected output regions
    localparam int P_ZERO = 0, P_ONES = 1, P_RING3 = 2, P_CORNER2 = 3,
                   P_CORNER3 = 4, P_RING5 = 5;
    // image ids
    localparam int I_ZERO = 0, I_SINGLE = 1, I_ONES = 2, I_ORIGIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        mode = 1'b0;
    logic        bin_in = 1'b0;

    logic        bin3, vld3, bin5, vld5;
    logic [11:0] col3, col5;
    logic [19:0] cnt3, cnt5;

    int vectors = 0;
    int misses  = 0;
    bit run_exp = 1'b0;

    always #5 clk = ~clk;

    morph_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .KSIZE(3), .COLOR_W(12)) u3 (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .mode(mode),
        .bin_in(bin_in), .bin_out(bin3), .color_out(col3), .valid_out(vld3),
        .set_count(cnt3));

    morph_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .KSIZE(5), .COLOR_W(12)) u5 (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .mode(mode),
        .bin_in(bin_in), .bin_out(bin5), .color_out(col5), .valid_out(vld5),
        .set_count(cnt5));

    function automatic bit pat(input int id, input int x, input int y);
        case (id)
            P_ONES:    return 1'b1;
            P_RING3:   return (x >= 4 && x <= 6 && y >= 2 && y <= 4);
            P_CORNER2: return (x <= 1 && y <= 1);
            P_CORNER3: return (x <= 2 && y <= 2);
            P_RING5:   return (x >= 3 && x <= 7 && y >= 1 && y <= 5);
            default:   return 1'b0;
        endcase
    endfunction

    function automatic bit img_px(input int id, input int h, input int v);
        case (id)
            I_SINGLE: return (h == 5 && v == 3);
            I_ONES:   return 1'b1;
            I_ORIGIN: return (h == 0 && v == 0);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int cnt_exp(input int c);
`ifdef MORPH_SET_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    // Drive one full raster frame and check every output cycle.
    // sw: mode switches to erode at (8,4); rst_h/rst_v: reset pulse position.
    task automatic run_frame(input int img, input bit md, input bit sw,
                             input int rst_h, input int rst_v,
                             input int e3, input int e5,
                             input int c3, input int c5);
        bit ev3, ev5, eb3, eb5, was_run, is_rst;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                hcount = 11'(h);
                vcount = 11'(v);
                bin_in = img_px(img, h, v);
                mode   = (sw && (v > 4 || (v == 4 && h >= 8))) ? 1'b1 : md;
                rst    = (h == rst_h && v == rst_v);
                @(posedge clk);
                #1;
                is_rst  = rst;
                was_run = run_exp;
                if (is_rst) run_exp = 1'b0;
                else if (h == 0 && v == 0) run_exp = 1'b1;
                ev3 = was_run && !is_rst && h >= 1 && h < H + 1 && v >= 1 && v < V + 1;
                ev5 = was_run && !is_rst && h >= 2 && h < H + 2 && v >= 2 && v < V + 2;
                eb3 = ev3 && pat(e3, h - 1, v - 1);
                eb5 = ev5 && pat(e5, h - 2, v - 2);
                vectors++;
                if (vld3 !== ev3 || bin3 !== eb3 || col3 !== {12{eb3}}) begin
                    misses++;
                    $display("FAIL k3_out h=%0d v=%0d got vld=%b bin=%b col=%h want vld=%b bin=%b",
                             h, v, vld3, bin3, col3, ev3, eb3);
                end
                vectors++;
                if (vld5 !== ev5 || bin5 !== eb5 || col5 !== {12{eb5}}) begin
                    misses++;
                    $display("FAIL k5_out h=%0d v=%0d got vld=%b bin=%b col=%h want vld=%b bin=%b",
                             h, v, vld5, bin5, col5, ev5, eb5);
                end
                if (h == 0 && v == 0 && !is_rst) begin
                    vectors++;
                    if (cnt3 !== 20'(cnt_exp(c3)) || cnt5 !== 20'(cnt_exp(c5))) begin
                        misses++;
                        $display("FAIL set_count_sof got k3=%0d k5=%0d want k3=%0d k5=%0d",
                                 cnt3, cnt5, cnt_exp(c3), cnt_exp(c5));
                    end
                end
                if (is_rst) begin
                    vectors++;
                    if (cnt3 !== 20'd0 || cnt5 !== 20'd0) begin
                        misses++;
                        $display("FAIL set_count_rst got k3=%0d k5=%0d want 0", cnt3, cnt5);
                    end
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        hcount = 11'd19; vcount = 11'd10; bin_in = 1'b1; mode = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (vld3 !== 1'b0 || bin3 !== 1'b0 || col3 !== 12'h000 || cnt3 !== 20'd0 ||
            vld5 !== 1'b0 || bin5 !== 1'b0 || col5 !== 12'h000 || cnt5 !== 20'd0) begin
            misses++;
            $display("FAIL reset_state got vld=%b/%b bin=%b/%b col=%h/%h cnt=%0d/%0d want all 0",
                     vld3, vld5, bin3, bin5, col3, col5, cnt3, cnt5);
        end
        @(negedge clk);
        rst = 1'b0; mode = 1'b0; bin_in = 1'b0;
        run_exp = 1'b0;
    endtask

    task automatic test_dilate_single();
        run_frame(I_SINGLE, 1'b0, 1'b0, -1, -1, P_RING3, P_RING5, 0, 0);
    endtask

    task automatic test_erode_single();
        run_frame(I_SINGLE, 1'b1, 1'b0, -1, -1, P_ZERO, P_ZERO, 9, 25);
    endtask

    task automatic test_erode_ones();
        run_frame(I_ONES, 1'b1, 1'b0, -1, -1, P_ONES, P_ONES, 0, 0);
    endtask

    task automatic test_dilate_corner();
        run_frame(I_ORIGIN, 1'b0, 1'b0, -1, -1, P_CORNER2, P_CORNER3, 128, 128);
    endtask

    task automatic test_mode_switch();
        run_frame(I_SINGLE, 1'b0, 1'b1, -1, -1, P_RING3, P_RING5, 4, 9);
        run_frame(I_SINGLE, 1'b1, 1'b0, -1, -1, P_ZERO, P_ZERO, 9, 25);
    endtask

    task automatic test_reset_mid_frame();
        run_frame(I_SINGLE, 1'b0, 1'b0, 10, 5, P_RING3, P_RING5, 0, 0);
        run_frame(I_SINGLE, 1'b0, 1'b0, -1, -1, P_RING3, P_RING5, 0, 0);
        run_frame(I_ZERO,   1'b0, 1'b0, -1, -1, P_ZERO, P_ZERO, 9, 25);
    endtask

    initial begin
        test_reset();
        test_dilate_single();
        test_erode_single();
        test_erode_ones();
        test_dilate_corner();
        test_mode_switch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
